// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: shared state type, digit count and segment codes for the scan controller
package seven_seg_pkg;
  localparam int NDIG = 4;
  typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1100111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;
endpackage

// File: rtl/seven_seg_scan_ctrl_seg_encode.sv
// seg_encode: BCD digit to {g,f,e,d,c,b,a}; non-decimal codes render as a dash
module seg_encode
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // pure lookup, every code covered
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed display scanner with blanking gap and frame-aligned loads
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int ON_CYC    = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            lz_en,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [15:0]     load_bcd,
  input  logic [NDIG-1:0] load_dp,
  output logic [6:0]      seg,
  output logic            seg_dp,
  output logic [NDIG-1:0] dig_en,
  output logic            frame_done
);
  localparam int MX = ON_CYC > BLANK_CYC ? (ON_CYC > 2 ? ON_CYC : 2) : (BLANK_CYC > 2 ? BLANK_CYC : 2);
  localparam int CW = $clog2(MX);
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
  state_t state, nstate;
  logic [1:0] k, nk;
  logic [CW-1:0] cnt, ncnt;
  logic [15:0] act, nact, pend, npend;
  logic [NDIG-1:0] act_dp, nact_dp, pend_dp, npend_dp;
  logic pfull, npfull, xfer, on_end, bl_end, bound, lz;
  logic [3:0] digit;
  logic [6:0] enc;
  assign load_ready = !pfull;
  assign xfer = load_valid && load_ready;
  assign on_end = state == ON && cnt == ON_LAST;
  assign bl_end = state == BLANK && cnt == BL_LAST;
  assign bound = en && k == 2'd3 && (bl_end || (on_end && BLANK_CYC == 0));
  // scan sequencing: IDLE -> ON(k) -> [BLANK(k)] -> ON(k+1) ..., en low always returns to IDLE
  always_comb begin
    nstate = state;
    nk = k;
    ncnt = cnt + 1'b1;
    if (!en) begin
      nstate = IDLE;
      nk = '0;
      ncnt = '0;
    end else if (state == IDLE) begin
      nstate = ON;
      nk = '0;
      ncnt = '0;
    end else if (on_end) begin
      nstate = BLANK_CYC == 0 ? ON : BLANK;
      nk = BLANK_CYC == 0 ? k + 1'b1 : k;
      ncnt = '0;
    end else if (bl_end) begin
      nstate = ON;
      nk = k + 1'b1;
      ncnt = '0;
    end
  end
  // loads land in active when idle, leaving, or on the frame boundary; otherwise they wait in pending
  always_comb begin
    nact = act;
    nact_dp = act_dp;
    npend = pend;
    npend_dp = pend_dp;
    npfull = pfull;
    if (xfer && (state == IDLE || !en || bound)) begin
      nact = load_bcd;
      nact_dp = load_dp;
    end else if (pfull && (!en || bound)) begin
      nact = pend;
      nact_dp = pend_dp;
      npfull = 1'b0;
    end else if (xfer) begin
      npend = load_bcd;
      npend_dp = load_dp;
      npfull = 1'b1;
    end
  end
  assign digit = nact[{nk, 2'b00} +: 4];
  assign lz = lz_en && nk != 2'd0 && (nact >> {nk, 2'b00}) == 16'd0;
  seg_encode u_enc (.bcd(digit), .seg(enc));
  // state, counter and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      act <= '0;
      act_dp <= '0;
      pend <= '0;
      pend_dp <= '0;
      pfull <= 1'b0;
    end else begin
      state <= nstate;
      k <= nk;
      cnt <= ncnt;
      act <= nact;
      act_dp <= nact_dp;
      pend <= npend;
      pend_dp <= npend_dp;
      pfull <= npfull;
    end
  end
  // display pins follow the next state so they switch on the same edge as the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      seg_dp <= 1'b0;
      dig_en <= '0;
      frame_done <= 1'b0;
    end else begin
      seg <= nstate == ON && !lz ? enc : SEG_OFF;
      seg_dp <= nstate == ON && nact_dp[nk];
      dig_en <= nstate == ON ? 4'b0001 << nk : 4'b0000;
      frame_done <= bound;
    end
  end
endmodule
